// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit, 7-segment display.
//   Each digit gets a slot of BLANK_CYCLES (all anodes off, segments
//   already showing the next glyph, which hides ghosting) followed by
//   DIGIT_PERIOD cycles with that digit's anode lit.
//
//   New display data is captured by 'load' into a pending shadow. The
//   shadow is promoted to the active registers only at a frame boundary,
//   so a frame never shows a mix of old and new digits.
//
//   Ports
//     ACLK        clock
//     ARESETN     asynchronous reset, active-low
//     enable      scan enable (level); low forces IDLE with everything dark
//     load        one-cycle pulse capturing digit_val/dp_val/digit_en
//     digit_val   four hex nibbles, digit k = bits [4k+3:4k]
//     dp_val      decimal point per digit
//     digit_en    per-digit display enable
//     brightness  PWM duty for the lit anode (only with the macro below)
//     an          digit anodes (polarity set by AN_ACTIVE_LOW)
//     seg         segments, bit order gfedcba (polarity set by SEG_ACTIVE_LOW)
//     dp          decimal point segment (same polarity as seg)
//     frame_done  one-cycle pulse at the end of the digit-3 slot
//     upd_ack     one-cycle pulse when pending data becomes active
//
//   Build option
//     SEG7_SCAN_BRIGHTNESS_EN  adds the brightness port and a 4-bit PWM
//                              counter gating the anode during SHOW.
module seg7_scan_ctrl #(
  parameter int DIGIT_PERIOD   = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digit_val,
  input  logic [3:0]  dp_val,
  input  logic [3:0]  digit_en,
`ifdef SEG7_SCAN_BRIGHTNESS_EN
  input  logic [3:0]  brightness,
`endif
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic        upd_ack
);

  localparam int CNT_MAX = (DIGIT_PERIOD > BLANK_CYCLES) ? DIGIT_PERIOD : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_PERIOD - 1);

  // "Off" levels; XOR-ing an active-high pattern into these applies polarity.
  localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW  != 0) ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic [15:0] act_val, pend_val;
  logic [3:0]  act_dp, pend_dp;
  logic [3:0]  act_en, pend_en;
  logic        pend;

`ifdef SEG7_SCAN_BRIGHTNESS_EN
  logic [3:0] pwm_cnt;
  logic [3:0] pwm_nxt;
  assign pwm_nxt = pwm_cnt + 4'd1;
`endif

  // Standard hex glyphs, active-high, gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'b0111111;
      4'h1: hex_to_seg = 7'b0000110;
      4'h2: hex_to_seg = 7'b1011011;
      4'h3: hex_to_seg = 7'b1001111;
      4'h4: hex_to_seg = 7'b1100110;
      4'h5: hex_to_seg = 7'b1101101;
      4'h6: hex_to_seg = 7'b1111101;
      4'h7: hex_to_seg = 7'b0000111;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1101111;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b1111100;
      4'hC: hex_to_seg = 7'b0111001;
      4'hD: hex_to_seg = 7'b1011110;
      4'hE: hex_to_seg = 7'b1111001;
      default: hex_to_seg = 7'b1110001;
    endcase
  endfunction

  logic blank_end, show_end, frame_wrap, boundary, apply;

  assign blank_end  = (state == BLANK) && (cnt == BLANK_LAST);
  assign show_end   = (state == SHOW)  && (cnt == SHOW_LAST);
  assign frame_wrap = show_end && (idx == 2'd3);
  assign boundary   = enable && ((state == IDLE) || frame_wrap);
  assign apply      = boundary && pend;

  // Look one cycle ahead: the segment register must already hold the glyph
  // for the digit (and data set) that will be current after this edge,
  // including pending data that is being promoted at this very boundary.
  logic [1:0]  nxt_idx;
  logic [15:0] nxt_val;
  logic [3:0]  nxt_dp;
  logic [3:0]  nxt_nib;
  logic [3:0]  idx_onehot;

  always_comb begin
    nxt_idx = idx;
    if (state == IDLE)
      nxt_idx = 2'd0;
    else if (show_end)
      nxt_idx = idx + 2'd1;
    nxt_val = apply ? pend_val : act_val;
    nxt_dp  = apply ? pend_dp  : act_dp;
    case (nxt_idx)
      2'd0:    nxt_nib = nxt_val[3:0];
      2'd1:    nxt_nib = nxt_val[7:4];
      2'd2:    nxt_nib = nxt_val[11:8];
      default: nxt_nib = nxt_val[15:12];
    endcase
    idx_onehot = act_en[idx] ? (4'b0001 << idx) : 4'b0000;
  end

  // Scan FSM, data shadow and all registered outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend       <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      frame_done <= 1'b0;
      upd_ack    <= 1'b0;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      pwm_cnt    <= 4'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      upd_ack    <= 1'b0;

      // A load in the same cycle as a promotion lands in pending and
      // keeps pend set, so it applies at the following boundary.
      if (load) begin
        pend_val <= digit_val;
        pend_dp  <= dp_val;
        pend_en  <= digit_en;
        pend     <= 1'b1;
      end else if (apply) begin
        pend     <= 1'b0;
      end

      if (apply) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        act_en  <= pend_en;
      end

      if (!enable) begin
        state <= IDLE;
        idx   <= 2'd0;
        cnt   <= '0;
        an    <= AN_OFF;
        seg   <= SEG_OFF;
        dp    <= DP_OFF;
      end else begin
        idx     <= nxt_idx;
        seg     <= SEG_OFF ^ hex_to_seg(nxt_nib);
        dp      <= DP_OFF ^ nxt_dp[nxt_idx];
        upd_ack <= apply;
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            an    <= AN_OFF;
          end
          BLANK: begin
            if (blank_end) begin
              state <= SHOW;
              cnt   <= '0;
              an    <= AN_OFF ^ idx_onehot;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
              pwm_cnt <= 4'd0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
              an  <= AN_OFF;
            end
          end
          SHOW: begin
            if (show_end) begin
              state      <= BLANK;
              cnt        <= '0;
              an         <= AN_OFF;
              frame_done <= frame_wrap;
            end else begin
              cnt <= cnt + 1'b1;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
              pwm_cnt <= pwm_nxt;
              an      <= AN_OFF ^ ((pwm_nxt <= brightness) ? idx_onehot : 4'b0000);
`else
              an      <= AN_OFF ^ idx_onehot;
`endif
            end
          end
          default: begin
            state <= IDLE;
            an    <= AN_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
//   Testbench for seg7_scan_ctrl (DIGIT_PERIOD=8, BLANK_CYCLES=2, both
//   polarities active-low). Expected outputs come from a frame-time model:
//   the position inside the frame alone gives slot, blank/show phase and
//   the digit, and a boundary happens on enable-from-idle or frame wrap.
module tb_seg7_scan_ctrl;

  localparam int DP_CYC = 8;
  localparam int BL_CYC = 2;
  localparam int SLOT   = DP_CYC + BL_CYC;
  localparam int FRAME  = 4 * SLOT;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digit_val = '0;
  logic [3:0]  dp_val = '0;
  logic [3:0]  digit_en = '0;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'd15;
`endif
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic        upd_ack;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_run  = 1'b0;
  int          m_t    = 0;
  bit          m_pend = 1'b0;
  logic [15:0] a_val = '0, p_val = '0;
  logic [3:0]  a_dp = '0, p_dp = '0, a_en = '0, p_en = '0;
  bit          e_fd = 1'b0, e_ack = 1'b0;

  always #5 ACLK = ~ACLK;

  seg7_scan_ctrl #(
    .DIGIT_PERIOD  (DP_CYC),
    .BLANK_CYCLES  (BL_CYC),
    .AN_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .enable    (enable),
    .load      (load),
    .digit_val (digit_val),
    .dp_val    (dp_val),
    .digit_en  (digit_en),
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done),
    .upd_ack   (upd_ack)
  );

  // Lit segments per hex glyph, gfedcba, active-high.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h (t=%0d run=%0d)", tag, obs, exp, m_t, m_run);
    end
  endtask

  // Compare every output against what the model says should be visible now.
  task automatic checkAll();
    logic [3:0] xan;
    logic [6:0] xseg;
    logic       xdp;
    int         slot, pos;
    xan  = 4'hF;
    xseg = 7'h7F;
    xdp  = 1'b1;
    if (m_run) begin
      slot = m_t / SLOT;
      pos  = m_t % SLOT;
      xseg = ~glyph(a_val[slot*4 +: 4]);
      xdp  = ~a_dp[slot];
`ifdef SEG7_SCAN_BRIGHTNESS_EN
      if (pos >= BL_CYC && a_en[slot] && (((pos - BL_CYC) % 16) <= int'(brightness)))
        xan[slot] = 1'b0;
`else
      if (pos >= BL_CYC && a_en[slot])
        xan[slot] = 1'b0;
`endif
    end
    checkOutput("an", 16'(an), 16'(xan));
    checkOutput("seg", 16'(seg), 16'(xseg));
    checkOutput("dp", 16'(dp), 16'(xdp));
    checkOutput("frame_done", 16'(frame_done), 16'(e_fd));
    checkOutput("upd_ack", 16'(upd_ack), 16'(e_ack));
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic modelStep();
    bit bnd;
    bnd   = 1'b0;
    e_fd  = 1'b0;
    e_ack = 1'b0;
    if (!enable) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_t   = 0;
      bnd   = 1'b1;
    end else begin
      m_t++;
      if (m_t == FRAME) begin
        m_t  = 0;
        bnd  = 1'b1;
        e_fd = 1'b1;
      end
    end
    if (bnd && m_pend) begin
      a_val  = p_val;
      a_dp   = p_dp;
      a_en   = p_en;
      m_pend = 1'b0;
      e_ack  = 1'b1;
    end
    if (load) begin
      p_val  = digit_val;
      p_dp   = dp_val;
      p_en   = digit_en;
      m_pend = 1'b1;
    end
  endtask

  task automatic modelReset();
    m_run = 1'b0; m_t = 0; m_pend = 1'b0;
    a_val = '0; p_val = '0; a_dp = '0; p_dp = '0; a_en = '0; p_en = '0;
    e_fd = 1'b0; e_ack = 1'b0;
  endtask

  task automatic applyStimulus(input bit en, input bit ld, input logic [15:0] v,
                               input logic [3:0] d, input logic [3:0] e);
    enable    = en;
    load      = ld;
    digit_val = v;
    dp_val    = d;
    digit_en  = e;
    @(posedge ACLK);
    modelStep();
    @(negedge ACLK);
    load = 1'b0;
    checkAll();
  endtask

  task automatic runCycles(input int n, input bit en);
    for (int i = 0; i < n; i++)
      applyStimulus(en, 1'b0, digit_val, dp_val, digit_en);
  endtask

  initial begin
    // Reset state
    modelReset();
    repeat (2) @(negedge ACLK);
    checkAll();
    ARESETN = 1'b1;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    brightness = 4'($urandom_range(0, 15));
`endif

    // First load while idle, then start scanning; two full frames.
    applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0000, 4'b1111);
    runCycles(2 * FRAME + 1, 1'b1);

    // Mid-frame update during digit 1; applies at the next boundary.
    for (int i = 0; i < FRAME && m_t != SLOT + 3; i++) runCycles(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'hABCD, 4'b1010, 4'b1111);
    runCycles(2 * FRAME, 1'b1);

    // Disable in the middle of digit 2's SHOW, then restart.
    for (int i = 0; i < FRAME && m_t != 2 * SLOT + 5; i++) runCycles(1, 1'b1);
    runCycles(3, 1'b0);
    runCycles(FRAME + 5, 1'b1);

    // Digit mask 0101.
    for (int i = 0; i < FRAME && m_t != 7; i++) runCycles(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h5678, 4'b0011, 4'b0101);
    runCycles(2 * FRAME, 1'b1);

    // Load exactly on the frame-wrap edge.
    for (int i = 0; i < FRAME && m_t != FRAME - 1; i++) runCycles(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h9E0F, 4'b0110, 4'b1011);
    runCycles(2 * FRAME, 1'b1);

    // Randomized traffic: occasional loads and enable drops.
    for (int i = 0; i < 900; i++)
      applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 11) == 0),
                    16'($urandom), 4'($urandom), 4'($urandom));

    // Asynchronous reset in the middle of a SHOW phase.
    runCycles(1, 1'b1);
    for (int i = 0; i < FRAME && (m_t % SLOT) < BL_CYC + 2; i++) runCycles(1, 1'b1);
    #2 ARESETN = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge ACLK);
    checkAll();
    ARESETN = 1'b1;
    runCycles(FRAME + 5, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_PERIOD, default 100000, ACLK cycles each digit is shown; legal range >=2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, ACLK cycles with all anodes off before each digit; legal range >=1.
REQ-003 SHALL have parameter AN_ACTIVE_LOW, default 1, 1 = anode outputs active-low.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1, 1 = segment and dp outputs active-low.
REQ-005 SHALL have one clock and an asynchronous active-low reset: ACLK  in  1  clock; ARESETN  in  1  async reset, active-low.
REQ-006 SHALL have port enable  in  1  scan enable (level).
REQ-007 SHALL have port load  in  1  one-cycle pulse capturing digit_val, dp_val and digit_en into the pending shadow.
REQ-008 SHALL have port digit_val  in  16  four hex nibbles; digit k = bits [4k+3:4k].
REQ-009 SHALL have port dp_val  in  4  decimal point per digit.
REQ-010 SHALL have port digit_en  in  4  per-digit display enable.
REQ-011 SHALL have port an  out  4  digit anodes.
REQ-012 SHALL have port seg  out  7  segments, bit order gfedcba.
REQ-013 SHALL have port dp  out  1  decimal point segment.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse at the end of the digit-3 slot.
REQ-015 SHALL have port upd_ack  out  1  one-cycle pulse when pending data becomes active.

Function
REQ-016 SHALL implement FSM states IDLE, BLANK and SHOW, plus a 2-bit digit index and a slot cycle counter.
REQ-017 In IDLE, with enable=1, the FSM SHALL go to BLANK with index 0 on the next cycle; this transition is a frame boundary.
REQ-018 BLANK SHALL last BLANK_CYCLES cycles with all anodes inactive and seg/dp already driving the pattern for the current index, then go to SHOW.
REQ-019 SHOW SHALL last DIGIT_PERIOD cycles with an[index] active only if active digit_en[index]=1, then go to BLANK with index+1, wrapping 3->0.
REQ-020 The SHOW(3)->BLANK(0) transition SHALL pulse frame_done and SHALL be a frame boundary.
REQ-021 A frame lasts exactly 4*(BLANK_CYCLES+DIGIT_PERIOD) cycles; disabled digits still consume their slot.
REQ-022 load SHALL write the pending shadow and set pend; a load while pend=1 overwrites the pending data.
REQ-023 At a frame boundary with pend=1, pending data SHALL copy to the active registers, pend SHALL clear and upd_ack SHALL pulse in the same cycle as the transition.
REQ-024 A load coinciding with a boundary SHALL land in pending; it applies at the following boundary.
REQ-025 seg SHALL be the standard hex decode 0-F of the active nibble (e.g. 4 = gfedcba 1100110 before polarity); dp SHALL equal active dp_val[index].
REQ-026 enable=0 in any state SHALL force IDLE on the next cycle: anodes, seg and dp inactive, index and counter cleared, pending retained.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 While ARESETN=0, the block SHALL hold: state IDLE, an all inactive, seg and dp inactive, frame_done=0, upd_ack=0, pend=0, and active/pending digit_val=0, dp_val=0, digit_en=0.

Configuration
REQ-029 When SEG7_SCAN_BRIGHTNESS_EN is defined, the block SHALL add port brightness  in  4, plus a 4-bit PWM counter that clears on SHOW entry and increments every cycle, wrapping 15->0.
REQ-030 With SEG7_SCAN_BRIGHTNESS_EN defined, the anode SHALL be active in SHOW only while pwm_cnt <= brightness; brightness=15 means always on.
REQ-031 Without SEG7_SCAN_BRIGHTNESS_EN, the brightness port and PWM logic SHALL be absent, and the anode is on for all of SHOW.

Verification (DIGIT_PERIOD=8, BLANK_CYCLES=2 unless stated)
REQ-032 Reset test: assert ARESETN=0 mid-SHOW -> an=1111, seg=1111111, dp=1 immediately; frame_done and upd_ack stay 0.
REQ-033 First load: load digit_val=0x1234, digit_en=1111, then enable=1 -> upd_ack on IDLE->BLANK; after 2 cycles an=1110 and seg=0011001 for 8 cycles; frame_done every 40 cycles.
REQ-034 Mid-frame update: load 0xABCD during digit 1 -> active stays 0x1234 until the boundary; upd_ack and frame_done coincide; the next frame shows D,C,B,A.
REQ-035 Disable mid-SHOW: drop enable -> next cycle an=1111; re-enable -> restart at BLANK digit 0.
REQ-036 Digit mask: digit_en=0101 -> an[1] and an[3] never asserted; frame period still 40 cycles.
REQ-037 Brightness (macro on, DIGIT_PERIOD=32): brightness=3 -> anode active 4 of every 16 SHOW cycles (8 per slot); brightness=15 -> active for all 32.
